// File: rtl/mandelbrot_iter_ctrl.sv
// Iteration controller for a Mandelbrot pixel engine: it sequences one ALU step per clock,
// detects escape or the iteration limit, and hands the count to the consumer.
module mandelbrot_iter_ctrl #(
    parameter int WIDTH  = 8,
    parameter int ITER_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_cr,
    input  logic [WIDTH-1:0]  in_ci,
    input  logic [ITER_W-1:0] in_max_iter,
    output logic [WIDTH-1:0]  alu_cr,
    output logic [WIDTH-1:0]  alu_ci,
    output logic [WIDTH-1:0]  alu_zr,
    output logic [WIDTH-1:0]  alu_zi,
    input  logic [WIDTH-1:0]  alu_out_zr,
    input  logic [WIDTH-1:0]  alu_out_zi,
    input  logic              alu_size,
    input  logic              alu_overflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITER_W-1:0] out_iter,
    output logic              out_escaped,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  cr_q, cr_d, ci_q, ci_d, zr_q, zr_d, zi_q, zi_d;
    logic [ITER_W-1:0] max_q, max_d, cnt_q, cnt_d, iter_q, iter_d;
    logic              esc_q, esc_d;
    logic [ITER_W-1:0] cnt_inc;

    // cnt never exceeds max_q, so this increment cannot wrap in practice
    assign cnt_inc = cnt_q + ITER_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cr_q    <= '0;
            ci_q    <= '0;
            zr_q    <= '0;
            zi_q    <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
            iter_q  <= '0;
            esc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cr_q    <= cr_d;
            ci_q    <= ci_d;
            zr_q    <= zr_d;
            zi_q    <= zi_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            iter_q  <= iter_d;
            esc_q   <= esc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cr_d    = cr_q;
        ci_d    = ci_q;
        zr_d    = zr_q;
        zi_d    = zi_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        iter_d  = iter_q;
        esc_d   = esc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cr_d  = in_cr;
                    ci_d  = in_ci;
                    max_d = in_max_iter;
                    zr_d  = '0;
                    zi_d  = '0;
                    cnt_d = '0;
                    // A zero limit finishes immediately without touching the ALU
                    if (in_max_iter == '0) begin
                        iter_d  = '0;
                        esc_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                // Escape wins over the limit, and the diverging z is not committed
                if (alu_size || alu_overflow) begin
                    iter_d  = cnt_q;
                    esc_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    zr_d  = alu_out_zr;
                    zi_d  = alu_out_zi;
                    cnt_d = cnt_inc;
                    if (cnt_inc == max_q) begin
                        iter_d  = max_q;
                        esc_d   = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == ITER) || (state_q == DONE);
    end

    assign alu_cr      = cr_q;
    assign alu_ci      = ci_q;
    assign alu_zr      = zr_q;
    assign alu_zi      = zi_q;
    assign out_iter    = iter_q;
    assign out_escaped = esc_q;

endmodule

// File: tb/tb_mandelbrot_iter_ctrl.sv
// Scoreboard bench for mandelbrot_iter_ctrl: the bench models the 2.6 fixed-point ALU,
// predicts each pixel's result with a plain iteration loop, and checks results as they emerge.
module tb_mandelbrot_iter_ctrl;

   localparam int WIDTH  = 8;
   localparam int ITER_W = 6;

   typedef struct {
      logic [ITER_W-1:0] iter;
      logic              esc;
      logic [WIDTH-1:0]  zr;
      logic [WIDTH-1:0]  zi;
      logic [WIDTH-1:0]  cr;
      logic [WIDTH-1:0]  ci;
      int                doneCycle;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [WIDTH-1:0]  in_cr = '0;
   logic [WIDTH-1:0]  in_ci = '0;
   logic [ITER_W-1:0] in_max_iter = '0;
   logic [WIDTH-1:0]  alu_cr, alu_ci, alu_zr, alu_zi;
   logic [WIDTH-1:0]  alu_out_zr, alu_out_zi;
   logic              alu_size, alu_overflow;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [ITER_W-1:0] out_iter;
   logic              out_escaped;
   logic              busy;

   int   checks = 0;
   int   errors = 0;
   int   cycle = 0;
   int   readyMode = 0;
   int   validCnt = 0;
   exp_t expQ[$];

   mandelbrot_iter_ctrl #(.WIDTH(WIDTH), .ITER_W(ITER_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_cr(in_cr), .in_ci(in_ci), .in_max_iter(in_max_iter),
      .alu_cr(alu_cr), .alu_ci(alu_ci), .alu_zr(alu_zr), .alu_zi(alu_zi),
      .alu_out_zr(alu_out_zr), .alu_out_zi(alu_out_zi),
      .alu_size(alu_size), .alu_overflow(alu_overflow),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_iter(out_iter), .out_escaped(out_escaped), .busy(busy)
   );

   // 10 ns clock; the cycle counter lets the monitor measure result latency
   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   // One Mandelbrot step in 2.6 fixed point: z' = z^2 + c, with |z|^2 > 4 and range flags
   function automatic void aluEval(input logic [WIDTH-1:0] zr, zi, cr, ci,
                                   output logic [WIDTH-1:0] nr, ni,
                                   output logic size, ovf);
      int a, b, c, d, r, i;
      a = $signed(zr);
      b = $signed(zi);
      c = $signed(cr);
      d = $signed(ci);
      r = ((a * a - b * b) >>> 6) + c;
      i = ((2 * a * b) >>> 6) + d;
      size = (a * a + b * b) > (4 << 12);
      ovf  = (r > 127) || (r < -128) || (i > 127) || (i < -128);
      nr = r[WIDTH-1:0];
      ni = i[WIDTH-1:0];
   endfunction

   always_comb aluEval(alu_zr, alu_zi, alu_cr, alu_ci, alu_out_zr, alu_out_zi, alu_size, alu_overflow);

   // Reference: iterate from z=0 until escape or the limit, and derive when DONE should appear
   function automatic exp_t refPixel(input logic [WIDTH-1:0] cr, ci, input logic [ITER_W-1:0] mx,
                                     input int acceptCycle);
      exp_t e;
      logic [WIDTH-1:0] nr, ni;
      logic sz, ov;
      e.cr = cr;
      e.ci = ci;
      e.zr = '0;
      e.zi = '0;
      e.iter = mx;
      e.esc = 1'b0;
      for (int k = 0; k < int'(mx); k++) begin
         aluEval(e.zr, e.zi, cr, ci, nr, ni, sz, ov);
         if (sz || ov) begin
            e.iter = ITER_W'(k);
            e.esc = 1'b1;
            break;
         end
         e.zr = nr;
         e.zi = ni;
      end
      e.doneCycle = acceptCycle + 1 + (e.esc ? int'(e.iter) + 1 : int'(mx));
      return e;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   // Stimulus side of the scoreboard: every accepted pixel pushes its predicted result
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready)
         expQ.push_back(refPixel(in_cr, in_ci, in_max_iter, cycle));
   end

   // Monitor: checks hold stability while stalled and pops the prediction on each handshake
   logic              prevValid = 1'b0;
   logic [ITER_W-1:0] prevIter = '0;
   logic              prevEsc = 1'b0;
   int                validStart = 0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prevValid = 1'b0;
      end else begin
         if (out_valid) begin
            if (!prevValid) begin
               validStart = cycle;
            end else begin
               checkOutput("held_iter", out_iter, prevIter);
               checkOutput("held_escaped", out_escaped, prevEsc);
            end
            if (out_ready) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_result", 1, 0);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("out_iter", out_iter, e.iter);
                  checkOutput("out_escaped", out_escaped, e.esc);
                  checkOutput("final_zr", alu_zr, e.zr);
                  checkOutput("final_zi", alu_zi, e.zi);
                  checkOutput("captured_cr", alu_cr, e.cr);
                  checkOutput("captured_ci", alu_ci, e.ci);
                  checkOutput("latency", validStart, e.doneCycle);
                  checkOutput("busy_in_done", busy, 1);
               end
            end
         end
         prevValid = out_valid && !out_ready;
         prevIter  = out_iter;
         prevEsc   = out_escaped;
      end
   end

   // Consumer: always ready, random backpressure, or a fixed five-cycle stall per result
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (out_valid) validCnt++;
         else validCnt = 0;
         case (readyMode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (validCnt > 5);
         endcase
      end
   end

   // Offer one pixel; while the DUT is busy, in_valid stays high with junk data that must be ignored
   task automatic applyStimulus(input logic [WIDTH-1:0] cr, ci, input logic [ITER_W-1:0] mx);
      int waitCycles = 0;
      bit taken = 0;
      while (!taken && waitCycles < 300) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         if (in_ready) begin
            in_cr = cr;
            in_ci = ci;
            in_max_iter = mx;
         end else begin
            in_cr = WIDTH'($urandom);
            in_ci = WIDTH'($urandom);
            in_max_iter = ITER_W'($urandom);
         end
         @(negedge clk);
         taken = in_ready;
         waitCycles++;
      end
      if (!taken) checkOutput("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic waitDrain();
      int n = 0;
      in_valid = 1'b0;
      while ((expQ.size() != 0 || busy) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain_timeout", (n < 2000) ? 1 : 0, 1);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_in_ready"}, in_ready, 1);
      checkOutput({tag, "_out_valid"}, out_valid, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_out_iter"}, out_iter, 0);
      checkOutput({tag, "_out_escaped"}, out_escaped, 0);
      checkOutput({tag, "_alu_ops"}, {alu_cr, alu_ci, alu_zr, alu_zi}, 0);
   endtask

   // Directed scenarios first, then a reset abort, then randomized back-to-back traffic
   initial begin
      repeat (3) @(negedge clk);
      checkResetOutputs("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      applyStimulus(8'h00, 8'h00, 6'd10);
      waitDrain();
      applyStimulus(8'h60, 8'h00, 6'd20);
      waitDrain();
      applyStimulus(8'h35, 8'hC3, 6'd0);
      waitDrain();

      readyMode = 2;
      applyStimulus(8'h60, 8'h00, 6'd20);
      applyStimulus(8'h10, 8'h08, 6'd3);
      waitDrain();
      readyMode = 0;

      applyStimulus(8'h00, 8'h00, 6'd30);
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      expQ.delete();
      checkResetOutputs("abort");
      @(negedge clk);
      checkResetOutputs("abort_held");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("abort_no_result", out_valid, 0);
      applyStimulus(8'hF0, 8'h20, 6'd12);
      waitDrain();

      readyMode = 1;
      for (int p = 0; p < 40; p++)
         applyStimulus(WIDTH'($urandom), WIDTH'($urandom), ITER_W'($urandom_range(0, 63)));
      for (int p = 0; p < 20; p++)
         applyStimulus(WIDTH'($urandom_range(0, 63) - 32), WIDTH'($urandom_range(0, 63) - 32),
                       ITER_W'($urandom_range(0, 40)));
      waitDrain();
      checkOutput("queue_empty", expQ.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
